// File: rtl/video_pattern_gen_if.sv
// Video output bus from the pattern generator to the display encoder.
interface video_pattern_gen_if #(
   parameter int unsigned COLOR_BITS = 8
);
   logic [COLOR_BITS-1:0] red;
   logic [COLOR_BITS-1:0] green;
   logic [COLOR_BITS-1:0] blue;
   logic                  de;
   logic                  hsync;
   logic                  vsync;
   logic                  starttrigger;
   logic                  frame_start;

   modport master (output red, green, blue, de, hsync, vsync, starttrigger, frame_start);
   modport slave  (input  red, green, blue, de, hsync, vsync, starttrigger, frame_start);
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing generator with frame-shadowed runtime timing and four test patterns,
// delivered through a fixed-latency output pipeline.
module video_pattern_gen #(
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned COLOR_BITS  = 8,
   parameter int unsigned PIPE_DELAY  = 2,
   parameter int unsigned CHECK_SHIFT = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] h_sync,
   input  logic [CNT_W-1:0] h_back_porch,
   input  logic [CNT_W-1:0] h_active,
   input  logic [CNT_W-1:0] h_total,
   input  logic [CNT_W-1:0] v_sync,
   input  logic [CNT_W-1:0] v_back_porch,
   input  logic [CNT_W-1:0] v_active,
   input  logic [CNT_W-1:0] v_total,
   input  logic             h_sync_pol,
   input  logic             v_sync_pol,
   input  logic [1:0]       pattern_mode,
   input  logic [CNT_W-1:0] box_x0,
   input  logic [CNT_W-1:0] box_x1,
   input  logic [CNT_W-1:0] box_y0,
   input  logic [CNT_W-1:0] box_y1,
   input  logic [CNT_W-1:0] bar_width,
   input  logic [7:0]       flash_interval,
   video_pattern_gen_if.master vid
);
   localparam int unsigned L  = PIPE_DELAY + 1;
   localparam int unsigned SW = CNT_W + 2;
   localparam int unsigned PW = 3 * COLOR_BITS + 5;

   logic [CNT_W-1:0] hs_s, hbp_s, ha_s, ht_s, vs_s, vbp_s, va_s, vt_s;
   logic [CNT_W-1:0] bx0_s, bx1_s, by0_s, by1_s, bw_s;
   logic             hpol_s, vpol_s;
   logic [1:0]       mode_s;

   logic [CNT_W-1:0] x, y, xpos, ypos;
   logic [7:0]       fc, fc_n;
   logic             box_on, box_on_n, trig_pend;
   logic [2:0]       bar_idx, bar_idx_n, cur_idx;
   logic [CNT_W-1:0] bar_cnt, bar_cnt_n, cur_cnt, bw_eff;
   logic             wrap_x, wrap_y, frame_wrap, act, st0;
   logic [SW-1:0]    h_start, h_end, v_start, v_end;
   logic [2:0]       rgb_on;
   logic [COLOR_BITS-1:0] r0, g0, b0;
   logic [PW-1:0]    s0, rst_word;
   logic [PW-1:0]    pipe [L];

   always_comb begin
      wrap_x     = (SW'(x) + SW'(1)) >= SW'(ht_s);
      wrap_y     = (SW'(y) + SW'(1)) >= SW'(vt_s);
      frame_wrap = wrap_x && wrap_y;
   end

   // Flash phase: fc counts frames within a phase, box_on flips at each phase end
   always_comb begin
      fc_n     = fc;
      box_on_n = box_on;
      if (flash_interval == 8'd0) begin
         fc_n     = 8'd0;
         box_on_n = 1'b0;
      end else if (fc >= flash_interval - 8'd1) begin
         fc_n     = 8'd0;
         box_on_n = ~box_on;
      end else begin
         fc_n = fc + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || frame_wrap) begin
         hs_s   <= h_sync;
         hbp_s  <= h_back_porch;
         ha_s   <= h_active;
         ht_s   <= h_total;
         vs_s   <= v_sync;
         vbp_s  <= v_back_porch;
         va_s   <= v_active;
         vt_s   <= v_total;
         hpol_s <= h_sync_pol;
         vpol_s <= v_sync_pol;
         mode_s <= pattern_mode;
         bx0_s  <= box_x0;
         bx1_s  <= box_x1;
         by0_s  <= box_y0;
         by1_s  <= box_y1;
         bw_s   <= bar_width;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         fc        <= '0;
         box_on    <= 1'b0;
         trig_pend <= 1'b0;
         bar_idx   <= '0;
         bar_cnt   <= '0;
      end else begin
         bar_idx <= bar_idx_n;
         bar_cnt <= bar_cnt_n;
         if (act) trig_pend <= 1'b0;
         if (wrap_x) begin
            x <= '0;
            y <= wrap_y ? '0 : y + CNT_W'(1);
         end else begin
            x <= x + CNT_W'(1);
         end
         if (frame_wrap) begin
            fc        <= fc_n;
            box_on    <= box_on_n;
            trig_pend <= box_on_n & ~box_on;
         end
      end
   end

   always_comb begin
      h_start = SW'(hs_s) + SW'(hbp_s);
      h_end   = h_start + SW'(ha_s);
      v_start = SW'(vs_s) + SW'(vbp_s);
      v_end   = v_start + SW'(va_s);
      xpos    = x - hs_s - hbp_s;
      ypos    = y - vs_s - vbp_s;
      act     = (SW'(x) >= h_start) && (SW'(x) < h_end) && (x < ht_s) &&
                (SW'(y) >= v_start) && (SW'(y) < v_end) && (y < vt_s);
   end

   // Bar index restarts at each line's first active pixel, then steps every bw_eff pixels
   always_comb begin
      bw_eff  = (bw_s == '0) ? CNT_W'(1) : bw_s;
      cur_idx = bar_idx;
      cur_cnt = bar_cnt;
      if (SW'(x) == h_start) begin
         cur_idx = '0;
         cur_cnt = '0;
      end
      bar_idx_n = cur_idx;
      bar_cnt_n = cur_cnt + CNT_W'(1);
      if (cur_cnt >= bw_eff - CNT_W'(1)) begin
         bar_cnt_n = '0;
         if (cur_idx != 3'd7) bar_idx_n = cur_idx + 3'd1;
      end
   end

   always_comb begin
      rgb_on = 3'b000;
      case (mode_s)
         2'd0: begin
            if (box_on && (xpos >= bx0_s) && (xpos < bx1_s) && (ypos >= by0_s) && (ypos < by1_s))
               rgb_on = 3'b111;
         end
         2'd1: begin
            case (cur_idx)
               3'd0:    rgb_on = 3'b111;
               3'd1:    rgb_on = 3'b110;
               3'd2:    rgb_on = 3'b011;
               3'd3:    rgb_on = 3'b010;
               3'd4:    rgb_on = 3'b101;
               3'd5:    rgb_on = 3'b100;
               3'd6:    rgb_on = 3'b001;
               default: rgb_on = 3'b000;
            endcase
         end
         2'd2:    rgb_on = {3{xpos[CHECK_SHIFT] ^ ypos[CHECK_SHIFT]}};
         default: rgb_on = 3'b000;
      endcase
      r0 = {COLOR_BITS{rgb_on[2]}};
      g0 = {COLOR_BITS{rgb_on[1]}};
      b0 = {COLOR_BITS{rgb_on[0]}};
      if (mode_s == 2'd3) begin
         r0 = xpos[COLOR_BITS-1:0];
         g0 = xpos[COLOR_BITS-1:0];
         b0 = xpos[COLOR_BITS-1:0];
      end
      if (!act) begin
         r0 = '0;
         g0 = '0;
         b0 = '0;
      end
      st0 = act && trig_pend && (mode_s == 2'd0);
      s0  = {st0, (x == '0) && (y == '0), (y < vs_s) ? vpol_s : ~vpol_s,
             (x < hs_s) ? hpol_s : ~hpol_s, act, r0, g0, b0};
      rst_word = {2'b00, ~v_sync_pol, ~h_sync_pol, 1'b0, {(3 * COLOR_BITS){1'b0}}};
   end

   // Output pipeline keeps every output aligned at latency L
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(L); i++) pipe[i] <= rst_word;
      end else begin
         pipe[0] <= s0;
         for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
      end
   end

   assign vid.starttrigger = pipe[L-1][PW-1];
   assign vid.frame_start  = pipe[L-1][PW-2];
   assign vid.vsync        = pipe[L-1][PW-3];
   assign vid.hsync        = pipe[L-1][PW-4];
   assign vid.de           = pipe[L-1][PW-5];
   assign vid.red          = pipe[L-1][3*COLOR_BITS-1:2*COLOR_BITS];
   assign vid.green        = pipe[L-1][2*COLOR_BITS-1:COLOR_BITS];
   assign vid.blue         = pipe[L-1][COLOR_BITS-1:0];
endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: frame-level reference model plus directed count/table checks.
module tb_video_pattern_gen;
   localparam int unsigned CNT_W = 12;
   localparam int unsigned CB    = 8;
   localparam int unsigned PD    = 2;
   localparam int unsigned CS    = 5;
   localparam int          L     = PD + 1;
   localparam int          PW    = 3 * CB + 5;

   logic clock;
   logic reset;
   logic [CNT_W-1:0] h_sync, h_back_porch, h_active, h_total;
   logic [CNT_W-1:0] v_sync, v_back_porch, v_active, v_total;
   logic h_sync_pol, v_sync_pol;
   logic [1:0] pattern_mode;
   logic [CNT_W-1:0] box_x0, box_x1, box_y0, box_y1, bar_width;
   logic [7:0] flash_interval;

   video_pattern_gen_if #(.COLOR_BITS(CB)) vid ();

   video_pattern_gen #(.CNT_W(CNT_W), .COLOR_BITS(CB), .PIPE_DELAY(PD), .CHECK_SHIFT(CS)) dut (
      .clock(clock), .reset(reset),
      .h_sync(h_sync), .h_back_porch(h_back_porch), .h_active(h_active), .h_total(h_total),
      .v_sync(v_sync), .v_back_porch(v_back_porch), .v_active(v_active), .v_total(v_total),
      .h_sync_pol(h_sync_pol), .v_sync_pol(v_sync_pol), .pattern_mode(pattern_mode),
      .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
      .bar_width(bar_width), .flash_interval(flash_interval), .vid(vid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int hs, hbp, ha, ht, vs, vbp, va, vt, hpol, vpol, mode, bx0, bx1, by0, by1, bw;
   } cfg_t;

   logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   cfg_t cur;
   int   t_pos, fnum, fi_r;
   logic [PW-1:0] expq [$];
   int   checks = 0;
   int   errors = 0;
   int   de_c, st_c, wh_c, hl_c;

   function automatic cfg_t snap();
      cfg_t c;
      c.hs = int'(h_sync);   c.hbp = int'(h_back_porch); c.ha = int'(h_active); c.ht = int'(h_total);
      c.vs = int'(v_sync);   c.vbp = int'(v_back_porch); c.va = int'(v_active); c.vt = int'(v_total);
      c.hpol = int'(h_sync_pol); c.vpol = int'(v_sync_pol); c.mode = int'(pattern_mode);
      c.bx0 = int'(box_x0); c.bx1 = int'(box_x1); c.by0 = int'(box_y0); c.by1 = int'(box_y1);
      c.bw = int'(bar_width);
      return c;
   endfunction

   // Box visibility of frame n: phases of fi_r frames, first phase off
   function automatic int box_on_f(int n);
      if (fi_r == 0) return 0;
      return (n / fi_r) % 2;
   endfunction

   // Expected output word for raster position t of frame n under config c
   function automatic logic [PW-1:0] exp_word(int t, cfg_t c, int n);
      int x, y, xp, yp, bi, bw;
      logic de, hs, vs, fs, st;
      logic [23:0] rgb;
      x  = t % c.ht;
      y  = t / c.ht;
      xp = x - c.hs - c.hbp;
      yp = y - c.vs - c.vbp;
      de = (xp >= 0) && (xp < c.ha) && (yp >= 0) && (yp < c.va);
      hs = (x < c.hs) ? (c.hpol != 0) : (c.hpol == 0);
      vs = (y < c.vs) ? (c.vpol != 0) : (c.vpol == 0);
      fs = (t == 0);
      st = de && (c.mode == 0) && (xp == 0) && (yp == 0) && (n > 0) &&
           (box_on_f(n) == 1) && (box_on_f(n - 1) == 0);
      rgb = 24'h0;
      if (de) begin
         case (c.mode)
            0: if (box_on_f(n) == 1 && xp >= c.bx0 && xp < c.bx1 && yp >= c.by0 && yp < c.by1)
                  rgb = 24'hFFFFFF;
            1: begin
               bw = (c.bw == 0) ? 1 : c.bw;
               bi = xp / bw;
               if (bi > 7) bi = 7;
               rgb = bar_rgb[bi];
            end
            2: if ((((xp >> CS) ^ (yp >> CS)) & 1) != 0) rgb = 24'hFFFFFF;
            default: rgb = {3{CB'(xp)}};
         endcase
      end
      return {st, fs, vs, hs, de, rgb};
   endfunction

   function automatic logic [PW-1:0] rst_word_f();
      return {2'b00, ~v_sync_pol, ~h_sync_pol, 1'b0, 24'h0};
   endfunction

   task automatic check_int(string tag, int obs, int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: advance the model and compare the full output word
   task automatic tick();
      logic [PW-1:0] obs, e;
      @(posedge clock);
      #1;
      if (reset) begin
         cur   = snap();
         fi_r  = int'(flash_interval);
         t_pos = 0;
         fnum  = 0;
         expq.delete();
         for (int i = 0; i < L; i++) expq.push_back(rst_word_f());
      end else begin
         expq.push_back(exp_word(t_pos, cur, fnum));
         t_pos++;
         if (t_pos == cur.ht * cur.vt) begin
            t_pos = 0;
            fnum++;
            cur = snap();
         end
      end
      e   = expq.pop_front();
      obs = {vid.starttrigger, vid.frame_start, vid.vsync, vid.hsync, vid.de,
             vid.red, vid.green, vid.blue};
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL pix t=%0d frame=%0d observed=%h expected=%h", t_pos, fnum, obs, e);
      end
   endtask

   task automatic clear_counts();
      de_c = 0; st_c = 0; wh_c = 0; hl_c = 0;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (vid.de) de_c++;
         if (vid.starttrigger) st_c++;
         if (vid.de && vid.red == 8'hFF && vid.green == 8'hFF && vid.blue == 8'hFF) wh_c++;
         if (!vid.hsync) hl_c++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic set_tiny();
      h_sync = 12'd2; h_back_porch = 12'd2; h_active = 12'd4; h_total = 12'd10;
      v_sync = 12'd1; v_back_porch = 12'd1; v_active = 12'd3; v_total = 12'd6;
      h_sync_pol = 1'b0; v_sync_pol = 1'b0;
   endtask

   task automatic wait_de();
      for (int k = 0; k < 600 && !vid.de; k++) tick();
      check_int("wait_de", int'(vid.de), 1);
   endtask

   task automatic randomize_cfg();
      h_sync       = CNT_W'($urandom_range(1, 8));
      h_back_porch = CNT_W'($urandom_range(0, 8));
      h_active     = CNT_W'($urandom_range(1, 70));
      h_total      = h_sync + h_back_porch + h_active + CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) h_total = h_total - CNT_W'($urandom_range(0, 2));
      v_sync       = CNT_W'($urandom_range(1, 3));
      v_back_porch = CNT_W'($urandom_range(0, 3));
      v_active     = CNT_W'($urandom_range(1, 24));
      v_total      = v_sync + v_back_porch + v_active + CNT_W'($urandom_range(0, 3));
      h_sync_pol   = 1'($urandom_range(0, 1));
      v_sync_pol   = 1'($urandom_range(0, 1));
      pattern_mode = 2'($urandom_range(0, 3));
      box_x0       = CNT_W'($urandom_range(0, 40));
      box_x1       = CNT_W'($urandom_range(0, 72));
      box_y0       = CNT_W'($urandom_range(0, 12));
      box_y1       = CNT_W'($urandom_range(0, 26));
      bar_width    = CNT_W'($urandom_range(0, 12));
   endtask

   initial begin
      int k, len0, len1;
      reset = 1'b1;
      set_tiny();
      pattern_mode = 2'd0; flash_interval = 8'd2; bar_width = 12'd1;
      box_x0 = 12'd0; box_x1 = 12'd4; box_y0 = 12'd0; box_y1 = 12'd3;

      // Tiny raster, flashing full-area box: 8 frames
      do_reset();
      check_int("rst_de", int'(vid.de), 0);
      check_int("rst_hsync_inactive", int'(vid.hsync), 1);
      check_int("rst_vsync_inactive", int'(vid.vsync), 1);
      clear_counts();
      run(479);
      check_int("tiny_de_count", de_c, 96);
      check_int("tiny_trigger_count", st_c, 2);
      check_int("tiny_white_count", wh_c, 48);
      check_int("tiny_hsync_low", hl_c, 96);

      // h_active change mid-frame takes effect only at the next frame
      do_reset();
      clear_counts();
      run(29);
      h_active = 12'd6;
      run(30);
      check_int("hact_cur_frame_de", de_c, 12);
      clear_counts();
      run(60);
      check_int("hact_next_frame_de", de_c, 18);
      h_active = 12'd4;

      // Colour bars, bar_width 2 then 0
      h_active = 12'd16; h_total = 12'd24; pattern_mode = 2'd1; bar_width = 12'd2;
      do_reset();
      wait_de();
      for (int p = 0; p < 16; p++) begin
         check_int("bar_w2", int'({vid.red, vid.green, vid.blue}), int'(bar_rgb[p / 2]));
         tick();
      end
      bar_width = 12'd0;
      do_reset();
      wait_de();
      for (int p = 0; p < 16; p++) begin
         check_int("bar_w0", int'({vid.red, vid.green, vid.blue}), int'(bar_rgb[(p > 7) ? 7 : p]));
         tick();
      end
      run(300);

      // One-cycle reset mid active line
      wait_de();
      run(3);
      do_reset();
      k = 0;
      while (k < 40 && !vid.frame_start) begin
         tick();
         k++;
      end
      check_int("frame_start_latency", k, L);

      // Flash interval zero keeps the box dark and never triggers
      set_tiny();
      pattern_mode = 2'd0; flash_interval = 8'd0;
      do_reset();
      clear_counts();
      run(240);
      check_int("fi0_white", wh_c, 0);
      check_int("fi0_trigger", st_c, 0);
      check_int("fi0_de", de_c, 48);

      // Randomised configurations with mid-frame reconfiguration
      for (int it = 0; it < 5; it++) begin
         randomize_cfg();
         flash_interval = 8'($urandom_range(0, 3));
         do_reset();
         len0 = int'(h_total) * int'(v_total);
         run(len0 / 2 + int'($urandom_range(0, 7)));
         randomize_cfg();
         len1 = int'(h_total) * int'(v_total);
         run(len0 + 2 * len1 + L);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
